dvsd_pe_rr: RTL and testbench

Parametrised registered priority encoder with fixed-priority and round-robin modes, WIDTH request lines, and a valid/ready handshake on both sides. Successor to the 8-bit fixed encoder on the user-project GPIO path. It keeps the cascade outputs (gs, eno), adds a rotating-priority pointer for fair arbitration, and applies backpressure. It sits between io_in/LA request sources and downstream logic in the user project.

---
 rtl/dvsd_pe_pkg.sv | 14 +
 rtl/dvsd_pe_search.sv | 40 ++++
 rtl/dvsd_pe_rr.sv | 118 +++++++++++
 tb/tb_dvsd_pe_rr.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dvsd_pe_pkg.sv
// Shared definitions for the dvsd_pe priority encoder family:
// mode encodings and the index-width helper used by every module.
package dvsd_pe_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Width of an index able to address n request lines; never returns 0,
    // so a degenerate width still yields a legal vector.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dvsd_pe_search.sv
// Combinational circular first-set search. Bits at or above 'start' are
// searched first; if none is set the plain request vector is searched,
// which yields the wrapped-around winner. With start=0 the result is the
// plain lowest-set-bit (fixed priority) encoding.
module dvsd_pe_search
    import dvsd_pe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [WIDTH-1:0] w_hi;

    // Index of the lowest set bit of v; zero when v is empty.
    function automatic logic [IDX_W-1:0] lowest(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // Keep only the requests at or above the start position.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_hi[i] = req[i] && (i >= int'(start));
        end
    end

    assign idx = (|w_hi) ? lowest(w_hi) : lowest(req);
    assign any = |req;

endmodule

// File: rtl/dvsd_pe_rr.sv
// Registered priority encoder with fixed-priority and round-robin modes.
// One result register stage behind a valid/ready handshake; the input is
// ready whenever the result slot is empty or being drained this cycle.
// The round-robin pointer only advances on round-robin grants and always
// stays inside 0..WIDTH-1, even when WIDTH is not a power of two.
module dvsd_pe_rr
    import dvsd_pe_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic             mode,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             gs,
    output logic             eno
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_gs;
    logic             r_eno;
    logic [IDX_W-1:0] r_ptr;

    logic             w_accept;
    logic             w_any;
    logic             w_fix_any;
    logic             w_rr_any;
    logic [IDX_W-1:0] w_fix_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             w_gs_nxt;
    logic             w_eno_nxt;
    logic             w_ptr_upd;
    logic [IDX_W-1:0] w_ptr_nxt;

    assign req_ready = !r_valid || out_ready;
    assign w_accept  = req_valid && req_ready;

    dvsd_pe_search #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_search_fix (
        .req   (req),
        .start ('0),
        .idx   (w_fix_idx),
        .any   (w_fix_any)
    );

    dvsd_pe_search #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_search_rr (
        .req   (req),
        .start (r_ptr),
        .idx   (w_rr_idx),
        .any   (w_rr_any)
    );

    assign w_any = (mode == MODE_RR) ? w_rr_any : w_fix_any;

    // Encode the offered request and work out the pointer update for an RR grant.
    always_comb begin
        w_idx_nxt = '0;
        w_gs_nxt  = 1'b0;
        w_eno_nxt = 1'b0;
        w_ptr_upd = 1'b0;
        w_ptr_nxt = r_ptr;
        if (en) begin
            if (!w_any) begin
                w_eno_nxt = 1'b1;
            end else begin
                w_gs_nxt = 1'b1;
                if (mode == MODE_RR) begin
                    w_idx_nxt = w_rr_idx;
                    w_ptr_upd = 1'b1;
                    w_ptr_nxt = (w_rr_idx == LAST_IDX) ? '0 : w_rr_idx + IDX_W'(1);
                end else begin
                    w_idx_nxt = w_fix_idx;
                end
            end
        end
    end

    // Result slot and RR pointer: load on accept, empty on consume, hold otherwise.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_gs    <= 1'b0;
            r_eno   <= 1'b0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= w_idx_nxt;
            r_gs    <= w_gs_nxt;
            r_eno   <= w_eno_nxt;
            if (w_ptr_upd) r_ptr <= w_ptr_nxt;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign gs        = r_gs;
    assign eno       = r_eno;

endmodule

// File: tb/tb_dvsd_pe_rr.sv
// Scoreboard bench for dvsd_pe_rr: an 8-wide and a 5-wide instance share
// clock and reset. Stimulus pushes the hand-computed result of each
// accepted request; per-instance monitors pop and compare on each consume.
module tb_dvsd_pe_rr;

    typedef struct packed {
        logic [2:0] idx;
        logic       gs;
        logic       eno;
    } exp_t;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;

    logic       en, mode, req_valid, req_ready, out_valid, out_ready, gs, eno;
    logic [7:0] req;
    logic [2:0] out_idx;

    logic       en5, mode5, req_valid5, req_ready5, out_valid5, out_ready5, gs5, eno5;
    logic [4:0] req5;
    logic [2:0] out_idx5;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;
    exp_t q8[$];
    exp_t q5[$];

    always #5 wb_clk_i = ~wb_clk_i;

    dvsd_pe_rr #(.WIDTH(8)) u_dut8 (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .en        (en),
        .mode      (mode),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .gs        (gs),
        .eno       (eno)
    );

    dvsd_pe_rr #(.WIDTH(5)) u_dut5 (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .en        (en5),
        .mode      (mode5),
        .req_valid (req_valid5),
        .req_ready (req_ready5),
        .req       (req5),
        .out_valid (out_valid5),
        .out_ready (out_ready5),
        .out_idx   (out_idx5),
        .gs        (gs5),
        .eno       (eno5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send8(input logic e, input logic m, input logic [7:0] r,
                         input logic [2:0] xi, input logic xg, input logic xe);
        exp_t x;
        bit   ok;
        ok = 1'b0;
        en = e; mode = m; req = r; req_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge wb_clk_i);
            if (req_ready) begin
                x.idx = xi; x.gs = xg; x.eno = xe;
                q8.push_back(x);
                ok = 1'b1;
            end
        end
        if (ok) begin
            @(posedge wb_clk_i);
            #1;
        end else begin
            check("send8 accept timeout", 32'd0, 32'd1);
        end
        req_valid = 1'b0;
    endtask

    task automatic send5(input logic e, input logic m, input logic [4:0] r,
                         input logic [2:0] xi, input logic xg, input logic xe);
        exp_t x;
        bit   ok;
        ok = 1'b0;
        en5 = e; mode5 = m; req5 = r; req_valid5 = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge wb_clk_i);
            if (req_ready5) begin
                x.idx = xi; x.gs = xg; x.eno = xe;
                q5.push_back(x);
                ok = 1'b1;
            end
        end
        if (ok) begin
            @(posedge wb_clk_i);
            #1;
        end else begin
            check("send5 accept timeout", 32'd0, 32'd1);
        end
        req_valid5 = 1'b0;
    endtask

    task automatic monitor8();
        exp_t x;
        while (!done) begin
            @(negedge wb_clk_i);
            if (!wb_rst_i && out_valid === 1'b1 && out_ready) begin
                if (q8.size() == 0) begin
                    check("sb8 unexpected result", 32'd1, 32'd0);
                end else begin
                    x = q8.pop_front();
                    check("sb8 out_idx", out_idx, x.idx);
                    check("sb8 gs", gs, x.gs);
                    check("sb8 eno", eno, x.eno);
                end
            end
        end
    endtask

    task automatic monitor5();
        exp_t x;
        while (!done) begin
            @(negedge wb_clk_i);
            if (!wb_rst_i && out_valid5 === 1'b1 && out_ready5) begin
                if (q5.size() == 0) begin
                    check("sb5 unexpected result", 32'd1, 32'd0);
                end else begin
                    x = q5.pop_front();
                    check("sb5 out_idx", out_idx5, x.idx);
                    check("sb5 gs", gs5, x.gs);
                    check("sb5 eno", eno5, x.eno);
                end
            end
        end
    endtask

    task automatic run();
        logic [2:0] sweep [9];
        sweep = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

        // Reset held for two edges while a request is offered.
        wb_rst_i = 1'b1;
        en = 1'b1; mode = 1'b1; req = 8'hFF; req_valid = 1'b1; out_ready = 1'b1;
        en5 = 1'b1; mode5 = 1'b1; req5 = 5'h1F; req_valid5 = 1'b1; out_ready5 = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst8 out_valid", out_valid, 1'b0);
        check("rst8 out_idx", out_idx, 3'd0);
        check("rst8 gs", gs, 1'b0);
        check("rst8 eno", eno, 1'b0);
        check("rst5 out_valid", out_valid5, 1'b0);
        check("rst5 out_idx", out_idx5, 3'd0);
        check("rst5 gs", gs5, 1'b0);
        check("rst5 eno", eno5, 1'b0);
        wb_rst_i = 1'b0;
        req_valid = 1'b0;
        req_valid5 = 1'b0;

        // First RR grant after reset starts from pointer 0 (ptr -> 1).
        send8(1'b1, 1'b1, 8'hFF, 3'd0, 1'b1, 1'b0);

        // Fixed priority, empty request, disabled encoder.
        send8(1'b1, 1'b0, 8'b1010_0100, 3'd2, 1'b1, 1'b0);
        send8(1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        send8(1'b0, 1'b0, 8'hFF, 3'd0, 1'b0, 1'b0);

        // Grant index 7 so the pointer wraps to 0, then a full sweep.
        send8(1'b1, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            send8(1'b1, 1'b1, 8'hFF, sweep[i], 1'b1, 1'b0);
        end

        // Wrap and skip: ptr=6 after idx 5, then 0 (ptr 1), then 3 (ptr 4).
        send8(1'b1, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0);
        send8(1'b1, 1'b1, 8'b0000_1001, 3'd0, 1'b1, 1'b0);
        send8(1'b1, 1'b1, 8'b0000_1001, 3'd3, 1'b1, 1'b0);

        // Drain, then stall the output with a fresh result (idx 4, ptr 5).
        @(posedge wb_clk_i);
        #1;
        out_ready = 1'b0;
        send8(1'b1, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0);
        en = 1'b1; mode = 1'b1; req = 8'hFF; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            check("bp req_ready", req_ready, 1'b0);
            check("bp out_valid", out_valid, 1'b1);
            check("bp out_idx held", out_idx, 3'd4);
            check("bp gs held", gs, 1'b1);
            check("bp eno held", eno, 1'b0);
        end
        @(posedge wb_clk_i);
        #1;
        out_ready = 1'b1;
        // Pointer was held at 5 during the stall.
        send8(1'b1, 1'b1, 8'hFF, 3'd5, 1'b1, 1'b0);
        check("bp no bubble out_valid", out_valid, 1'b1);

        // WIDTH=5: pointer wraps to 0 after idx 4; fixed mode leaves it alone.
        send5(1'b1, 1'b1, 5'b00100, 3'd2, 1'b1, 1'b0);
        send5(1'b1, 1'b1, 5'b10001, 3'd4, 1'b1, 1'b0);
        send5(1'b1, 1'b1, 5'b10001, 3'd0, 1'b1, 1'b0);
        send5(1'b1, 1'b0, 5'b10000, 3'd4, 1'b1, 1'b0);
        send5(1'b1, 1'b1, 5'b10001, 3'd4, 1'b1, 1'b0);
        send5(1'b1, 1'b1, 5'b10001, 3'd0, 1'b1, 1'b0);
        send5(1'b1, 1'b1, 5'b00000, 3'd0, 1'b0, 1'b1);

        repeat (4) @(posedge wb_clk_i);
        #1;
        check("sb8 leftover entries", q8.size(), 0);
        check("sb5 leftover entries", q5.size(), 0);
    endtask

    initial begin
        fork
            monitor8();
            monitor5();
            begin
                run();
                done = 1'b1;
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
